// File: rtl/riu_decode_stage_if.sv
// rtl/riu_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface riu_decode_stage_if #(
    parameter int XLEN = 32
);
    // fetch side
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    // execute side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [11:0]     out_csr;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_itype;
    logic [4:0]      out_instr;
    logic            out_illegal;

    // environment: offers instructions and consumes decoded entries
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_csr, out_imm, out_itype, out_instr, out_illegal
    );

    // decode stage
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
               out_funct3, out_csr, out_imm, out_itype, out_instr, out_illegal
    );
endinterface

// File: rtl/riu_decode_stage.sv
// rtl/riu_decode_stage.sv - registered RV32 decode stage with decoded-entry FIFO
module riu_decode_stage #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int ENABLE_M = 1,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    riu_decode_stage_if.slave    bus,
    output logic [CNT_W-1:0]     illegal_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_FW = $clog2(DEPTH + 1);

    // class codes
    localparam logic [2:0] IT_R   = 3'd0;
    localparam logic [2:0] IT_I   = 3'd1;
    localparam logic [2:0] IT_U   = 3'd2;
    localparam logic [2:0] IT_B   = 3'd3;
    localparam logic [2:0] IT_J   = 3'd4;
    localparam logic [2:0] IT_S   = 3'd5;
    localparam logic [2:0] IT_ILL = 3'd7;

    // operation codes
    localparam logic [4:0] OP_AND   = 5'd0;
    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_ADD   = 5'd3;
    localparam logic [4:0] OP_SUB   = 5'd4;
    localparam logic [4:0] OP_MUL   = 5'd5;
    localparam logic [4:0] OP_MULH  = 5'd6;
    localparam logic [4:0] OP_MULHU = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SLT   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_SLTU  = 5'd12;
    localparam logic [4:0] OP_CSRRW = 5'd13;
    localparam logic [4:0] OP_LUI   = 5'd14;
    localparam logic [4:0] OP_AUIPC = 5'd15;
    localparam logic [4:0] OP_BEQ   = 5'd16;
    localparam logic [4:0] OP_BNE   = 5'd17;
    localparam logic [4:0] OP_BLT   = 5'd18;
    localparam logic [4:0] OP_BGE   = 5'd19;
    localparam logic [4:0] OP_BLTU  = 5'd20;
    localparam logic [4:0] OP_BGEU  = 5'd21;
    localparam logic [4:0] OP_JAL   = 5'd22;
    localparam logic [4:0] OP_JALR  = 5'd23;
    localparam logic [4:0] OP_LW    = 5'd24;
    localparam logic [4:0] OP_SW    = 5'd25;

    // the raw word is kept so the plain field slices need no separate storage
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     word;
        logic [XLEN-1:0] imm;
        logic [2:0]      itype;
        logic [4:0]      op;
        logic            illegal;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_FW-1:0]  count;

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [2:0]         d_itype;
    logic [4:0]         d_op;
    logic [XLEN-1:0]    d_imm;
    logic               d_illegal;
    logic               accept;
    logic               pop;
    entry_t             head;
    entry_t             dec_entry;

    assign opc = bus.in_instr[6:0];
    assign f3  = bus.in_instr[14:12];
    assign f7  = bus.in_instr[31:25];

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // class and operation lookup; anything not matched stays illegal with op 0
    always_comb begin
        d_itype = IT_ILL;
        d_op    = OP_AND;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    d_itype = IT_R;
                    case (f3)
                        3'b000:  d_op = OP_ADD;
                        3'b001:  d_op = OP_SLL;
                        3'b010:  d_op = OP_SLT;
                        3'b011:  d_op = OP_SLTU;
                        3'b100:  d_op = OP_XOR;
                        3'b101:  d_op = OP_SRL;
                        3'b110:  d_op = OP_OR;
                        default: d_op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    {d_itype, d_op} = {IT_R, OP_SUB};
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    {d_itype, d_op} = {IT_R, OP_SRA};
                end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
                    case (f3)
                        3'b000:  {d_itype, d_op} = {IT_R, OP_MUL};
                        3'b001:  {d_itype, d_op} = {IT_R, OP_MULH};
                        3'b011:  {d_itype, d_op} = {IT_R, OP_MULHU};
                        default: {d_itype, d_op} = {IT_ILL, OP_AND};
                    endcase
                end
            end
            7'b1110011: begin
                if (f3 == 3'b001) {d_itype, d_op} = {IT_R, OP_CSRRW};
            end
            7'b0010011: begin
                case (f3)
                    3'b000: {d_itype, d_op} = {IT_I, OP_ADD};
                    3'b010: {d_itype, d_op} = {IT_I, OP_SLT};
                    3'b011: {d_itype, d_op} = {IT_I, OP_SLTU};
                    3'b100: {d_itype, d_op} = {IT_I, OP_XOR};
                    3'b110: {d_itype, d_op} = {IT_I, OP_OR};
                    3'b111: {d_itype, d_op} = {IT_I, OP_AND};
                    3'b001: begin
                        if (f7 == 7'b0000000) {d_itype, d_op} = {IT_I, OP_SLL};
                    end
                    default: begin
                        if (f7 == 7'b0000000)      {d_itype, d_op} = {IT_I, OP_SRL};
                        else if (f7 == 7'b0100000) {d_itype, d_op} = {IT_I, OP_SRA};
                    end
                endcase
            end
            7'b0000011: begin
                if (f3 == 3'b010) {d_itype, d_op} = {IT_I, OP_LW};
            end
            7'b1100111: begin
                if (f3 == 3'b000) {d_itype, d_op} = {IT_I, OP_JALR};
            end
            7'b0110111: {d_itype, d_op} = {IT_U, OP_LUI};
            7'b0010111: {d_itype, d_op} = {IT_U, OP_AUIPC};
            7'b1100011: begin
                case (f3)
                    3'b000:  {d_itype, d_op} = {IT_B, OP_BEQ};
                    3'b001:  {d_itype, d_op} = {IT_B, OP_BNE};
                    3'b100:  {d_itype, d_op} = {IT_B, OP_BLT};
                    3'b101:  {d_itype, d_op} = {IT_B, OP_BGE};
                    3'b110:  {d_itype, d_op} = {IT_B, OP_BLTU};
                    3'b111:  {d_itype, d_op} = {IT_B, OP_BGEU};
                    default: {d_itype, d_op} = {IT_ILL, OP_AND};
                endcase
            end
            7'b1101111: {d_itype, d_op} = {IT_J, OP_JAL};
            7'b0100011: begin
                if (f3 == 3'b010) {d_itype, d_op} = {IT_S, OP_SW};
            end
            default: {d_itype, d_op} = {IT_ILL, OP_AND};
        endcase
    end

    assign d_illegal = (d_itype == IT_ILL);

    // immediate assembly by class, sign-extended from bit 31
    always_comb begin
        d_imm = '0;
        case (d_itype)
            IT_I: d_imm = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
            IT_S: d_imm = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
            IT_B: d_imm = {{(XLEN-13){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                           bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
            IT_U: d_imm = {{(XLEN-32){bus.in_instr[31]}}, bus.in_instr[31:12], 12'b0};
            IT_J: d_imm = {{(XLEN-21){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                           bus.in_instr[20], bus.in_instr[30:21], 1'b0};
            default: d_imm = '0;
        endcase
    end

    assign dec_entry = '{pc: bus.in_pc, word: bus.in_instr, imm: d_imm,
                         itype: d_itype, op: d_op, illegal: d_illegal};

    // ready looks only at the registered count, so a pop never frees a slot in the same cycle
    assign bus.in_ready  = (count < CNT_FW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    assign head            = mem[rd_ptr];
    assign bus.out_pc      = head.pc;
    assign bus.out_opcode  = head.word[6:0];
    assign bus.out_rd      = head.word[11:7];
    assign bus.out_rs1     = head.word[19:15];
    assign bus.out_rs2     = head.word[24:20];
    assign bus.out_funct3  = head.word[14:12];
    assign bus.out_csr     = head.word[31:20];
    assign bus.out_imm     = head.imm;
    assign bus.out_itype   = head.itype;
    assign bus.out_instr   = head.op;
    assign bus.out_illegal = head.illegal;

    // FIFO storage, pointers, occupancy and the saturating illegal counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            // stale storage is left in place; out_valid is low so nobody reads it
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= dec_entry;
                wr_ptr      <= bump(wr_ptr);
                if (d_illegal && illegal_cnt != {CNT_W{1'b1}})
                    illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            if (accept && !pop)      count <= count + CNT_FW'(1);
            else if (!accept && pop) count <= count - CNT_FW'(1);
        end
    end

endmodule

// File: doc/riu_decode_stage.md
Name: riu_decode_stage

Overview:
- Registered RV32 instruction-decode stage for the RIU core. Sits between fetch and execute.
- Decodes each accepted instruction word into the fields and type/op codes used by the execute unit.
- Covers R, I, U, B, J, S and load classes, sign-extends immediates, and flags illegal encodings.
- Buffers decoded results in a DEPTH-entry FIFO with valid/ready handshakes on both sides, plus a flush input and an illegal-instruction counter.

Parameters:
- XLEN, 32, width of pc and immediate datapath (>=32).
- DEPTH, 2, decoded-entry FIFO depth (>=1).
- ENABLE_M, 1, when 0, mul/mulh/mulhu decode as illegal.
- CNT_W, 8, width of the saturating illegal counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered and same-cycle input
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  pc of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_pc  out  XLEN  pc of head
- out_opcode  out  7  instr[6:0]
- out_rd  out  5  instr[11:7]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]; also shamt
- out_funct3  out  3  instr[14:12]
- out_csr  out  12  instr[31:20]
- out_imm  out  XLEN  sign-extended immediate
- out_itype  out  3  class code
- out_instr  out  5  operation code
- out_illegal  out  1  head is an illegal encoding
- illegal_cnt  out  CNT_W  illegal instructions accepted

Behaviour:
- Reset (async, rst_n low):
  - FIFO count=0; out_valid=0; in_ready=1.
  - All out_* data outputs =0; illegal_cnt=0.
- Accept and pop:
  - accept = in_valid & in_ready; in_ready = (count<DEPTH), depending only on registered count.
  - No pass-through when full; a same-cycle pop does not open a slot for that cycle.
  - pop = out_valid & out_ready; out_valid = (count>0); outputs show the head entry.
  - Simultaneous accept and pop leaves count unchanged. Order is strict FIFO.
- Latency: decoding is combinational on in_instr and stored at accept. An instruction is visible at the outputs 1 cycle after accept if the FIFO was empty.
- Class codes (itype):
  - R=0: opcodes 0110011 and 1110011.
  - I=1: 0010011, 0000011, 1100111.
  - U=2: 0110111, 0010111.
  - B=3: 1100011.
  - J=4: 1101111.
  - S=5: 0100011.
  - illegal=7.
- Operation codes (instr):
  - and 0, or 1, xor 2, add/addi 3, sub 4, mul 5, mulh 6, mulhu 7.
  - sll/slli 8, srl/srli 9, slt/slti 10, sra/srai 11, sltu/sltiu 12, csrrw 13.
  - lui 14, auipc 15.
  - beq 16, bne 17, blt 18, bge 19, bltu 20, bgeu 21.
  - jal 22, jalr 23, lw 24, sw 25.
- Operation selection:
  - R: funct7=0000001 selects M ops (funct3 000/001/011 only).
  - R: funct7=0100000 selects sub (funct3 000) or sra (funct3 101).
  - I shifts: funct7 bit5 selects srai.
- Illegal encodings (illegal=1, itype=7, instr=0):
  - unlisted opcode;
  - unlisted funct3 or funct7 combination;
  - M op with ENABLE_M=0;
  - 1110011 with funct3!=001;
  - load/store with funct3!=010;
  - jalr with funct3!=000.
- Immediates, sign-extended to XLEN from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and illegal: 0.
- illegal_cnt increments on accept of an illegal word and saturates at all-ones.
- Flush:
  - count->0 next cycle.
  - A same-cycle accept is discarded and does not count toward illegal_cnt.
  - illegal_cnt is kept.
  - in_ready=1 the following cycle.
- Reset mid-stream drops all entries immediately.

Test Plan:
- Decode R add: 0x002081B3 -> itype 0, instr 3, rd 3, rs1 1, rs2 2, imm 0, illegal 0, out_valid 1 cycle after accept.
- Decode immediates:
  - 0xFFF00093 (addi x1,x0,-1) -> itype 1, instr 3, imm 0xFFFFFFFF.
  - 0x123452B7 (lui x5) -> itype 2, instr 14, imm 0x12345000.
  - 0x00209463 (bne x1,x2,+8) -> itype 3, instr 17, imm 8.
- Illegal detection:
  - 0x00000000 -> illegal 1, itype 7, illegal_cnt 1.
  - With ENABLE_M=0, 0x022081B3 (mul) -> illegal 1, illegal_cnt 2.
  - With CNT_W=2, five illegal words -> illegal_cnt holds at 3.
- Backpressure with DEPTH=2 and out_ready=0: offer 3 words -> in_ready drops after 2 accepts. Raise out_ready -> outputs appear in order with no loss or duplication.
- Flush with 2 entries buffered and in_valid=1 on the flush cycle -> out_valid 0 next cycle, the in-flight word is absent, in_ready 1.
- Async reset asserted mid-stream between clock edges -> out_valid and illegal_cnt go to 0 immediately, without waiting for a clock edge.
